// File: rtl/xbar_bank_arbiter.sv
// Per-bank round-robin arbiter: picks one of NumReq upstream channels and
// registers its payload in a single output slot with full-throughput valid/ready.
module xbar_bank_arbiter #(
    parameter int NumReq       = 3,
    parameter int PayloadWidth = 64,
    parameter int SrcWidth     = $clog2(NumReq)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NumReq-1:0]              req_valid,
    output logic [NumReq-1:0]              req_ready,
    input  logic [NumReq*PayloadWidth-1:0] req_payload,
    output logic                           bank_req_valid,
    input  logic                           bank_req_ready,
    output logic [PayloadWidth-1:0]        bank_req_payload,
    output logic [SrcWidth-1:0]            bank_req_src,
    output logic [SrcWidth-1:0]            rr_ptr
);

    // Handshake (both sides): a beat moves on a rising edge where valid and
    // ready are both high; valid never waits on ready, and a stalled output
    // beat keeps payload/src stable until accepted.

    logic                    bank_req_valid_q, bank_req_valid_d;
    logic [PayloadWidth-1:0] bank_req_payload_q, bank_req_payload_d;
    logic [SrcWidth-1:0]     bank_req_src_q, bank_req_src_d;
    logic [SrcWidth-1:0]     rr_ptr_q, rr_ptr_d;

    logic                    slot_free;
    logic                    grant_vld;
    logic [SrcWidth-1:0]     grant_idx;
    logic [PayloadWidth-1:0] grant_payload;
    logic                    xfer;
    logic [NumReq-1:0]       grant_ready;

    // Gated by rst_n so nothing is accepted while the slot is held in reset.
    assign slot_free = rst_n & (~bank_req_valid_q | bank_req_ready);

    // Two passes: indices at/above the pointer first, then the wrapped-around ones.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int j = 0; j < NumReq; j++) begin
            if (!grant_vld && (j >= int'(rr_ptr_q)) && req_valid[j]) begin
                grant_vld = 1'b1;
                grant_idx = SrcWidth'(j);
            end
        end
        for (int j = 0; j < NumReq; j++) begin
            if (!grant_vld && (j < int'(rr_ptr_q)) && req_valid[j]) begin
                grant_vld = 1'b1;
                grant_idx = SrcWidth'(j);
            end
        end
    end

    always_comb begin
        grant_payload = '0;
        for (int j = 0; j < NumReq; j++) begin
            if (grant_idx == SrcWidth'(j)) begin
                grant_payload = req_payload[j*PayloadWidth +: PayloadWidth];
            end
        end
    end

    assign xfer = grant_vld & slot_free;

    always_comb begin
        grant_ready = '0;
        for (int j = 0; j < NumReq; j++) begin
            grant_ready[j] = xfer && (grant_idx == SrcWidth'(j));
        end
    end

    always_comb begin
        bank_req_valid_d   = bank_req_valid_q;
        bank_req_payload_d = bank_req_payload_q;
        bank_req_src_d     = bank_req_src_q;
        rr_ptr_d           = rr_ptr_q;
        if (xfer) begin
            bank_req_valid_d   = 1'b1;
            bank_req_payload_d = grant_payload;
            bank_req_src_d     = grant_idx;
            // Explicit wrap: NumReq need not be a power of two.
            rr_ptr_d           = (grant_idx == SrcWidth'(NumReq - 1)) ? '0
                                                                      : grant_idx + SrcWidth'(1);
        end else if (bank_req_ready) begin
            bank_req_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_req_valid_q   <= 1'b0;
            bank_req_payload_q <= '0;
            bank_req_src_q     <= '0;
            rr_ptr_q           <= '0;
        end else begin
            bank_req_valid_q   <= bank_req_valid_d;
            bank_req_payload_q <= bank_req_payload_d;
            bank_req_src_q     <= bank_req_src_d;
            rr_ptr_q           <= rr_ptr_d;
        end
    end

    assign req_ready        = grant_ready;
    assign bank_req_valid   = bank_req_valid_q;
    assign bank_req_payload = bank_req_payload_q;
    assign bank_req_src     = bank_req_src_q;
    assign rr_ptr           = rr_ptr_q;

    a_ready_onehot : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(req_ready));
    a_ready_needs_valid : assert property (@(posedge clk) disable iff (!rst_n)
        (req_ready & ~req_valid) == '0);
    a_src_in_range : assert property (@(posedge clk) disable iff (!rst_n)
        int'(bank_req_src_q) < NumReq);
    a_stall_hold : assert property (@(posedge clk) disable iff (!rst_n)
        (bank_req_valid_q && !bank_req_ready) |=>
            (bank_req_valid_q && $stable(bank_req_payload_q) && $stable(bank_req_src_q)));

endmodule

// File: tb/tb_xbar_bank_arbiter.sv
// Bench for xbar_bank_arbiter: directed scenarios plus random soak, checked
// against a round-robin reference model feeding an expected-output queue.
module tb_xbar_bank_arbiter;

    localparam int N  = 3;
    localparam int PW = 64;
    localparam int SW = $clog2(N);
    localparam int W  = SW + PW;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*PW-1:0] req_payload;
    logic            bank_req_valid;
    logic            bank_req_ready;
    logic [PW-1:0]   bank_req_payload;
    logic [SW-1:0]   bank_req_src;
    logic [SW-1:0]   rr_ptr;

    xbar_bank_arbiter #(.NumReq(N), .PayloadWidth(PW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_payload      (req_payload),
        .bank_req_valid   (bank_req_valid),
        .bank_req_ready   (bank_req_ready),
        .bank_req_payload (bank_req_payload),
        .bank_req_src     (bank_req_src),
        .rr_ptr           (rr_ptr)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Output slot and priority pointer tracked abstractly; winner found by a
    // modulo scan from the pointer. Runs on the falling edge, inputs stable.
    bit           m_valid;
    int           m_ptr;
    int           m_w;
    logic [N-1:0] m_exp_rdy;
    logic [N-1:0] m_xv;
    int           wait_cnt[N];

    always @(negedge clk) begin
        if (!rst_n) begin
            m_valid = 1'b0;
            m_ptr   = 0;
            exp_q.delete();
            for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        end else begin
            m_w = -1;
            for (int k = 0; k < N; k++) begin
                if (m_w < 0 && req_valid[(m_ptr + k) % N]) m_w = (m_ptr + k) % N;
            end
            m_exp_rdy = '0;
            if (m_w >= 0 && (!m_valid || bank_req_ready)) m_exp_rdy[m_w] = 1'b1;

            check("req_ready", req_ready, m_exp_rdy);
            check("rr_ptr", rr_ptr, m_ptr);
            check("bank_req_valid", bank_req_valid, m_valid);

            // Starvation bound, measured on the DUT's own accepts.
            m_xv = req_valid & req_ready;
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || m_xv[i]) begin
                    wait_cnt[i] = 0;
                end else if (m_xv != '0) begin
                    wait_cnt[i]++;
                    check($sformatf("wait_bound_%0d", i), wait_cnt[i] <= N - 1, 1'b1);
                end
            end

            if (m_exp_rdy != '0) begin
                exp_q.push_back({SW'(m_w), req_payload[m_w*PW +: PW]});
                m_valid = 1'b1;
                m_ptr   = (m_w + 1) % N;
            end else if (bank_req_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // ---------------- output monitor ----------------
    logic [W-1:0] mon_front;

    always @(negedge clk) begin
        if (rst_n && bank_req_valid) begin
            if (exp_q.size() == 0) begin
                check("out_without_expect", bank_req_valid, 1'b0);
            end else begin
                mon_front = exp_q[0];
                check("out_src", bank_req_src, mon_front[W-1 -: SW]);
                check("out_payload", bank_req_payload, mon_front[PW-1:0]);
                if (bank_req_ready) void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycle(input logic [N-1:0] v, input logic rdy);
        @(posedge clk);
        #1;
        req_valid      = v;
        bank_req_ready = rdy;
    endtask

    task automatic rand_payload();
        for (int i = 0; i < N; i++) req_payload[i*PW +: PW] = {$urandom(), $urandom()};
    endtask

    task automatic fixed_payload();
        req_payload = {64'hA2, 64'hA1, 64'hA0};
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n          = 1'b0;
        req_valid      = '0;
        bank_req_ready = 1'b1;
        fixed_payload();

        // Reset hold with random requests: nothing accepted, outputs cleared.
        while ($time < 450) begin
            @(negedge clk);
            req_valid = N'($urandom_range(0, (1 << N) - 1));
            #1;
            check("rst_valid", bank_req_valid, 1'b0);
            check("rst_ready", req_ready, '0);
            check("rst_ptr", rr_ptr, '0);
            check("rst_src", bank_req_src, '0);
            check("rst_payload", bank_req_payload, '0);
        end
        req_valid = '0;
        #2;
        rst_n = 1'b1;

        // Rotation with all requesters valid.
        for (int k = 0; k < 7; k++) begin
            cycle((k < 6) ? 3'b111 : 3'b000, 1'b1);
            @(negedge clk);
            if (k > 0) begin
                check("rot_src", bank_req_src, (k - 1) % 3);
                check("rot_payload", bank_req_payload, 64'hA0 + 64'((k - 1) % 3));
                check("rot_valid", bank_req_valid, 1'b1);
            end
        end

        // Stall hold on a captured src 1 beat.
        cycle(3'b010, 1'b1);
        for (int k = 0; k < 5; k++) begin
            cycle(3'b111, 1'b0);
            @(negedge clk);
            check("stall_src", bank_req_src, 1);
            check("stall_payload", bank_req_payload, 64'hA1);
            check("stall_ready", req_ready, '0);
            check("stall_ptr", rr_ptr, 2);
            check("stall_valid", bank_req_valid, 1'b1);
        end
        cycle(3'b111, 1'b1);
        cycle(3'b000, 1'b1);
        @(negedge clk);
        check("after_stall_src", bank_req_src, 2);

        // Skip idle requesters and wrap the pointer.
        cycle(3'b010, 1'b1);
        cycle(3'b001, 1'b1);
        cycle(3'b100, 1'b1);
        @(negedge clk);
        check("skip_src", bank_req_src, 0);
        check("skip_ptr", rr_ptr, 1);
        cycle(3'b000, 1'b1);
        @(negedge clk);
        check("wrap_src", bank_req_src, 2);
        check("wrap_ptr", rr_ptr, 0);

        // Drain without refill.
        cycle(3'b010, 1'b1);
        cycle(3'b000, 1'b1);
        @(negedge clk);
        check("drain_valid_hi", bank_req_valid, 1'b1);
        check("drain_src", bank_req_src, 1);
        cycle(3'b000, 1'b1);
        @(negedge clk);
        check("drain_valid_lo", bank_req_valid, 1'b0);
        check("drain_ptr", rr_ptr, 2);
        check("drain_src_kept", bank_req_src, 1);

        // Random soak, bank always ready (25 us).
        for (int k = 0; k < 2500; k++) begin
            rand_payload();
            cycle(N'($urandom_range(0, (1 << N) - 1)), 1'b1);
        end

        // Random soak with back-pressure.
        for (int k = 0; k < 1000; k++) begin
            rand_payload();
            cycle(N'($urandom_range(0, (1 << N) - 1)), $urandom_range(0, 3) != 0);
        end

        // Asynchronous reset in the middle of traffic.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", bank_req_valid, 1'b0);
        check("async_rst_ptr", rr_ptr, '0);
        check("async_rst_ready", req_ready, '0);
        @(posedge clk);
        #2;
        req_valid = '0;
        rst_n     = 1'b1;

        for (int k = 0; k < 50; k++) begin
            rand_payload();
            cycle(N'($urandom_range(0, (1 << N) - 1)), 1'b1);
        end
        for (int k = 0; k < 3; k++) cycle(3'b000, 1'b1);
        @(negedge clk);
        #1;
        check("queue_empty", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
